// File: rtl/ip_accum_ctrl.sv
// ip_accum_ctrl: accumulates a stream of sign-magnitude products into one
// sign-magnitude sum by time-sharing an external combinational adder.
//
// Ports:
//   iCLK, iRSTn       clock (rising edge), async active-low reset
//   iStart, iLen      start pulse and term count (sampled in IDLE only)
//   iValid/oReady     product handshake, iProd is the product
//   oAddEn/oAdd1/oAdd2/iAddout  external adder enable, operands, result
//   oBusy, oDone      busy in ACC/DONE, one-cycle completion pulse
//   oResult, oOvf     final sum and saturation flag, held until next start
module ip_accum_ctrl #(
    parameter int unsigned BIT_WIDTH = 15,
    parameter int unsigned SUM_WIDTH = 19,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iStart,
    input  logic [LEN_WIDTH-1:0] iLen,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [BIT_WIDTH-1:0] iProd,
    output logic                 oAddEn,
    output logic [SUM_WIDTH-1:0] oAdd1,
    output logic [SUM_WIDTH-1:0] oAdd2,
    input  logic [SUM_WIDTH-1:0] iAddout,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [SUM_WIDTH-1:0] oResult,
    output logic                 oOvf
);

    localparam int unsigned MAG_W = SUM_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t               state;
    logic [SUM_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] cnt;
    logic [SUM_WIDTH-1:0] nextAcc;
    logic                 satHit;
    logic                 handshake;

    assign oAdd1     = acc;
    // Sign stays at the MSB, magnitude zero-extended into the wider field.
    assign oAdd2     = {iProd[BIT_WIDTH-1], MAG_W'(iProd[BIT_WIDTH-2:0])};
    assign handshake = iValid & oReady;

    // Next accumulator value: saturate on magnitude wrap, normalise -0 to +0.
    always_comb begin
        satHit  = 1'b0;
        nextAcc = iAddout;
        if ((acc[SUM_WIDTH-1] == iProd[BIT_WIDTH-1]) &&
            (iAddout[MAG_W-1:0] < acc[MAG_W-1:0])) begin
            satHit  = 1'b1;
            nextAcc = {acc[SUM_WIDTH-1], {MAG_W{1'b1}}};
        end
        if (nextAcc[MAG_W-1:0] == '0) begin
            nextAcc = '0;
        end
    end

    // Sequencer with registered outputs.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            oResult <= '0;
            oOvf    <= 1'b0;
            oDone   <= 1'b0;
            oReady  <= 1'b0;
            oAddEn  <= 1'b0;
            oBusy   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        acc   <= '0;
                        oOvf  <= 1'b0;
                        cnt   <= iLen;
                        oBusy <= 1'b1;
                        if (iLen == '0) begin
                            state   <= DONE;
                            oDone   <= 1'b1;
                            oResult <= '0;
                        end else begin
                            state  <= ACC;
                            oReady <= 1'b1;
                            oAddEn <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (handshake) begin
                        acc <= nextAcc;
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (satHit) begin
                            oOvf <= 1'b1;
                        end
                        // Last term: result is registered so it lines up with oDone.
                        if (cnt == LEN_WIDTH'(1)) begin
                            state   <= DONE;
                            oDone   <= 1'b1;
                            oReady  <= 1'b0;
                            oAddEn  <= 1'b0;
                            oResult <= nextAcc;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    oReady <= 1'b0;
                    oAddEn <= 1'b0;
                    oBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ip_accum_ctrl.md
Name: ip_accum_ctrl

Overview:
Sequencer that accumulates a stream of sign-magnitude products into one sign-magnitude inner-product sum. It does this by time-sharing a single external combinational sign-magnitude adder, which is instantiated with BIT_WIDTH = SUM_WIDTH. The block sits between the 8-bit multiplier array and the LSTM gate logic. It owns the term counter, the accumulator register, the overflow/saturation logic and the start/done handshake.

Parameters:
BIT_WIDTH, 15, width of each incoming sign-magnitude product (MSB = sign)
SUM_WIDTH, 19, width of accumulator and result, sign-magnitude (MSB = sign); must be > BIT_WIDTH
LEN_WIDTH, 8, width of term-count input

Ports:
iCLK  input  1  clock, rising edge
iRSTn  input  1  reset, asynchronous, active-low
iStart  input  1  start pulse; sampled only in IDLE
iLen  input  LEN_WIDTH  number of terms to accumulate, latched on accepted iStart
iValid  input  1  product valid
oReady  output  1  product accepted when iValid & oReady
iProd  input  BIT_WIDTH  sign-magnitude product
oAddEn  output  1  adder enable, 1 only in ACC
oAdd1  output  SUM_WIDTH  adder operand 1 = accumulator register
oAdd2  output  SUM_WIDTH  adder operand 2 = widened iProd
iAddout  input  SUM_WIDTH  combinational adder result
oBusy  output  1  1 in ACC and DONE
oDone  output  1  one-cycle pulse when the result is final
oResult  output  SUM_WIDTH  final sum; held until the next accepted iStart
oOvf  output  1  saturation occurred in the current/last operation; held with oResult

Behaviour:
- Reset (iRSTn=0, asynchronous):
  - state=IDLE; accumulator, counter, oResult all 0.
  - oOvf=0, oDone=0, oReady=0.
  - Reset mid-operation discards the partial sum; no oDone is issued.
- Widening of iProd into oAdd2:
  - oAdd2[SUM_WIDTH-1] = iProd[BIT_WIDTH-1].
  - Magnitude zero-extended to SUM_WIDTH-1 bits.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - oReady=0, oBusy=0.
  - On iStart: accumulator<=0, oOvf<=0, counter<=iLen.
  - If iLen==0, go to DONE; otherwise go to ACC.
- ACC:
  - oReady=1, oAddEn=1.
  - Each handshake (iValid & oReady): accumulator <= next value, counter decremented.
  - Handshake with counter==1 -> DONE.
  - Cycles with iValid=0 change nothing; no timeout.
- Next accumulator value:
  - Overflow = same signs AND iAddout magnitude < accumulator magnitude.
  - On overflow: keep the accumulator sign, magnitude = all ones, set oOvf sticky.
  - Otherwise take iAddout.
  - Negative zero (sign 1, magnitude 0) is normalised to +0 before the register write.
- DONE, lasting exactly 1 cycle:
  - oDone=1, oReady=0.
  - oResult <= accumulator, registered so it is visible the same cycle as oDone.
  - Next state is IDLE.
  - iStart in DONE is ignored.
- iStart while in ACC or DONE is ignored; the current operation is unaffected.
- Latency:
  - N-term operation: oDone rises 1 cycle after the N-th handshake.
  - Minimum total is N+1 cycles after the iStart cycle.
  - iLen==0: oDone occurs in the cycle after iStart, with oResult=+0.
- oResult and oOvf are stable from oDone until the next accepted iStart. On that iStart, oOvf clears and oResult is kept.

Test Plan:
- Basic accumulation: iStart with iLen=3; products +5, +7, -3 with iValid held high -> oDone 1 cycle after the 3rd accept, oResult=+9, oOvf=0.
- Zero length: iStart with iLen=0 -> no oReady, oDone on the next cycle, oResult=0, oOvf=0.
- Cancellation: iLen=2; products +4, -4 -> oResult=19'h00000 (no negative zero).
- Backpressure: iLen=3; iValid pattern 1,0,0,1,0,1 with products -2, -3, -1 -> exactly 3 accepts, oResult sign=1 magnitude=6, oDone after the 6th stimulus cycle.
- Saturation: iLen=17; every product = +16383 -> after 16 terms the sum is 262128; the 17th saturates -> oResult magnitude 262143, sign 0, oOvf=1. A following 1-term op with +1 -> oOvf=0.
- Reset and restart: assert iRSTn=0 after the 2nd accept of a 4-term op -> all outputs 0 immediately, no oDone. A fresh iLen=1 op with +1 -> oResult=+1. Also assert iStart during ACC and check it is ignored (counter unaffected).
